// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI receiver slice.
// FSM states, SPI mode encodings and counter sizing.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with optional registered edge pulses.
// Flops reset to the line's idle level so reset causes no edge.
module spi_edge_sync #(
  parameter int p_stages = 2,
  parameter bit p_idle   = 1'b0,
  parameter bit p_edges  = 1'b1
) (
  input  logic clk,
  input  logic s_rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [p_stages-1:0] chain;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      chain <= {p_stages{p_idle}};
    end else begin
      chain <= {chain[p_stages-2:0], d};
    end
  end

  assign level = chain[p_stages-1];

  if (p_edges) begin : g_edge
    logic prev;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
      if (s_rst) begin
        prev   <= p_idle;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        prev   <= level;
        rise_q <= level & ~prev;
        fall_q <= ~level & prev;
      end
    end

    assign rise = rise_q;
    assign fall = fall_q;
  end else begin : g_lvl
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver: oversampled pins, MSB-first shift,
// one-entry valid/ready word buffer, overrun/frame error flags.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int p_data_width  = 8,
  parameter bit p_cpol        = 1'b0,
  parameter bit p_cpha        = 1'b0,
  parameter int p_sync_stages = 2
) (
  input  logic                    clk,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic [p_data_width-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    overrun,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int cw = cnt_w(p_data_width);
  localparam int sw = $clog2(p_sync_stages + 1);
  localparam logic [1:0] mode = {p_cpol, p_cpha};
  localparam bit fall_smp = (mode == SPI_MODE1) ||
                            (mode == SPI_MODE2);

  state_t                  state;
  logic [cw-1:0]           cnt;
  logic [sw-1:0]           settle;
  logic [p_data_width-1:0] sh;
  logic [p_data_width-1:0] word;
  logic                    sck_rise;
  logic                    sck_fall;
  logic                    cs_s;
  logic                    mosi_s;
  logic                    sample;
  logic                    done;
  logic                    unused_sck_lvl;
  logic                    unused_cs_r;
  logic                    unused_cs_f;
  logic                    unused_mo_r;
  logic                    unused_mo_f;

  spi_edge_sync #(
    .p_stages(p_sync_stages),
    .p_idle  (p_cpol),
    .p_edges (1'b1)
  ) u_sck (
    .clk  (clk),
    .s_rst(s_rst),
    .d    (sck),
    .level(unused_sck_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_edge_sync #(
    .p_stages(p_sync_stages),
    .p_idle  (1'b1),
    .p_edges (1'b0)
  ) u_cs (
    .clk  (clk),
    .s_rst(s_rst),
    .d    (cs_n),
    .level(cs_s),
    .rise (unused_cs_r),
    .fall (unused_cs_f)
  );

  spi_edge_sync #(
    .p_stages(p_sync_stages),
    .p_idle  (1'b0),
    .p_edges (1'b0)
  ) u_mosi (
    .clk  (clk),
    .s_rst(s_rst),
    .d    (mosi),
    .level(mosi_s),
    .rise (unused_mo_r),
    .fall (unused_mo_f)
  );

  assign sample = fall_smp ? sck_fall : sck_rise;
  assign word   = {sh[p_data_width-2:0], mosi_s};
  assign done   = (state == SHIFT) && !cs_s && sample &&
                  (cnt == cw'(p_data_width - 1));
  assign busy   = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      settle    <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (valid && ready) begin
        valid <= 1'b0;
      end

      if (done) begin
        if (!valid || ready) begin
          data  <= word;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      unique case (state)
        WAIT_IDLE: begin
          // cs_n chain still holds its reset value until flushed
          if (settle != sw'(p_sync_stages)) begin
            settle <= settle + 1'b1;
          end else if (cs_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          cnt <= '0;
          sh  <= '0;
          if (!cs_s) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            if (cnt != '0) begin
              frame_err <= 1'b1;
            end
            cnt   <= '0;
            sh    <= '0;
            state <= IDLE;
          end else if (sample) begin
            sh  <= word;
            cnt <= done ? '0 : cnt + 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver in modes 0 and 3.
// Stimulus pushes expected words; a monitor pops on handshakes.
module tb_spi_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       s_rst;
  logic       sck0, cs0, mosi0, ready0;
  logic       sck1, cs1, mosi1, ready1;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ovp0, ovp1, fep0, fep1;
  logic       busy0, busy1;

  int total = 0;
  int bad   = 0;
  int hs0 = 0, hs1 = 0;
  int ov0 = 0, ov1 = 0;
  int fe0 = 0, fe1 = 0;
  int busy_low = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  spi_receiver #(
    .p_data_width(8), .p_cpol(1'b0),
    .p_cpha(1'b0), .p_sync_stages(2)
  ) u0 (
    .clk(clk), .s_rst(s_rst), .sck(sck0),
    .cs_n(cs0), .mosi(mosi0), .data(data0),
    .valid(valid0), .ready(ready0),
    .overrun(ovp0), .frame_err(fep0), .busy(busy0)
  );

  spi_receiver #(
    .p_data_width(8), .p_cpol(1'b1),
    .p_cpha(1'b1), .p_sync_stages(2)
  ) u1 (
    .clk(clk), .s_rst(s_rst), .sck(sck1),
    .cs_n(cs1), .mosi(mosi1), .data(data1),
    .valid(valid1), .ready(ready1),
    .overrun(ovp1), .frame_err(fep1), .busy(busy1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!s_rst) begin
      if (valid0 && ready0) begin
        hs0++;
        if (q0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb0_extra: got %0h want none", data0);
        end else begin
          chk("sb0_data", data0, q0.pop_front());
        end
      end
      if (valid1 && ready1) begin
        hs1++;
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb1_extra: got %0h want none", data1);
        end else begin
          chk("sb1_data", data1, q1.pop_front());
        end
      end
      if (ovp0) ov0++;
      if (ovp1) ov1++;
      if (fep0) fe0++;
      if (fep1) fe1++;
    end
  end

  task automatic set_cs(input int inst, input logic v);
    if (inst == 0) cs0 = v;
    else cs1 = v;
  endtask

  task automatic set_mosi(input int inst, input logic v);
    if (inst == 0) mosi0 = v;
    else mosi1 = v;
  endtask

  // half sck period is 4 clk; inst 0 is mode 0, inst 1 is mode 3
  task automatic frame(input int inst, input logic [15:0] bits,
                       input int nbits, input int rst_at,
                       input bit lat, input bit rdy_late);
    set_cs(inst, 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b = bits[15-i];
      if (inst == 0) begin
        mosi0 = b;
        repeat (4) @(negedge clk);
        sck0 = 1'b1;
        if (rst_at < 0 && !busy0) busy_low++;
        if (i == nbits - 1 && lat) begin
          repeat (3) @(negedge clk);
          chk("lat_early", valid0, 0);
          @(negedge clk);
          chk("lat_hit", valid0, 1);
          chk("lat_data", data0, 8'h14);
        end else begin
          repeat (4) @(negedge clk);
        end
        sck0 = 1'b0;
      end else begin
        sck1 = 1'b0;
        mosi1 = b;
        repeat (4) @(negedge clk);
        sck1 = 1'b1;
        if (i == nbits - 1 && rdy_late) begin
          repeat (3) @(negedge clk);
          ready1 = 1'b1;
          @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
      end
      if (i + 1 == rst_at) begin
        @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    set_cs(inst, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    s_rst = 1'b1;
    sck0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0; ready0 = 1'b1;
    sck1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0; ready1 = 1'b0;
    repeat (3) @(negedge clk);
    s_rst = 1'b0;
    chk("rst_data", data0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_flags", {ovp0, fep0}, 0);
    repeat (6) @(negedge clk);

    q0.push_back(8'h14);
    frame(0, 16'h1400, 8, -1, 1'b1, 1'b0);
    chk("t1_ovr", ov0, 0);
    chk("t1_ferr", fe0, 0);

    busy_low = 0;
    q0.push_back(8'h03);
    q0.push_back(8'h57);
    frame(0, 16'h0357, 16, -1, 1'b0, 1'b0);
    chk("t2_busy", busy_low, 0);
    chk("t2_hs", hs0, 3);

    ready0 = 1'b0;
    frame(0, 16'h4512, 16, -1, 1'b0, 1'b0);
    chk("t3_ovr", ov0, 1);
    chk("t3_valid", valid0, 1);
    chk("t3_data", data0, 8'h45);
    q0.push_back(8'h45);
    ready0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_drain", valid0, 0);
    chk("t3_hs", hs0, 4);

    frame(0, 16'hB000, 5, -1, 1'b0, 1'b0);
    chk("t4_ferr", fe0, 1);
    chk("t4_hs", hs0, 4);
    q0.push_back(8'hA5);
    frame(0, 16'hA500, 8, -1, 1'b0, 1'b0);
    chk("t4_hs2", hs0, 5);

    frame(0, 16'hFF00, 8, 3, 1'b0, 1'b0);
    chk("t5_hs", hs0, 5);
    chk("t5_ferr", fe0, 1);
    chk("t5_valid", valid0, 0);
    chk("t5_data", data0, 0);
    q0.push_back(8'h3C);
    frame(0, 16'h3C00, 8, -1, 1'b0, 1'b0);
    chk("t5_hs2", hs0, 6);

    q1.push_back(8'h5A);
    q1.push_back(8'hC3);
    frame(1, 16'h5A00, 8, -1, 1'b0, 1'b0);
    chk("t6_valid", valid1, 1);
    chk("t6_hold", data1, 8'h5A);
    frame(1, 16'hC300, 8, -1, 1'b0, 1'b1);
    chk("t6_ovr", ov1, 0);
    chk("t6_ferr", fe1, 0);
    chk("t6_hs", hs1, 2);

    for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++)
      @(negedge clk);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_receiver.md
Name: spi_receiver

Overview:
SPI slave-side receiver; the far end of the team's SPI transmitter link. Oversamples external sck, cs_n and mosi in the local clk domain and shifts in MSB-first words. Presents each completed word on a one-entry valid/ready output buffer. Flags overrun and truncated frames. Sits between the SPI pins and the downstream word consumer.

Parameters:
p_data_width, 8, bits per word
p_cpol, 0, sck idle level
p_cpha, 0, 0 = sample on leading sck edge, 1 = sample on trailing edge
p_sync_stages, 2, synchronizer flops per input (minimum 2)

Ports:
clk  input  1  system clock; the only clock
s_rst  input  1  synchronous reset, active-high
sck  input  1  SPI serial clock, asynchronous to clk
cs_n  input  1  chip select, active-low, asynchronous
mosi  input  1  serial data, MSB first, asynchronous
data  output  p_data_width  received word; stable while valid=1
valid  output  1  data holds an unconsumed word
ready  input  1  consumer accepts data when valid&&ready
overrun  output  1  one-cycle pulse: a word completed while the buffer was full, and the new word was dropped
frame_err  output  1  one-cycle pulse: cs_n rose with 1..p_data_width-1 bits shifted
busy  output  1  1 while state=SHIFT

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on s_rst. No other reset.
- Timing constraint: sck high and low phases are each at least 3 clk periods. Faster sck is unsupported.
- Synchronizers: p_sync_stages flops each on sck, cs_n and mosi. One extra sck flop supplies edge detection.
- Sample edge:
  - rising when p_cpol^p_cpha=0; falling otherwise.
  - mosi is sampled from its synchronized value in the sample-edge cycle.
- Reset values: data=0, valid=0, overrun=0, frame_err=0, busy=0, bit count=0, shift register=0. Synchronizer flops load idle levels (sck=p_cpol, cs_n=1, mosi=0), so no spurious edge follows reset.
- States:
  - WAIT_IDLE (reset state): ignores edges. Goes to IDLE when synchronized cs_n=1.
  - IDLE: goes to SHIFT when synchronized cs_n=0. Bit count and shift register are cleared.
  - SHIFT: on each sample edge, shift mosi in at the LSB and increment the count.
- Word completion: when the count reaches p_data_width, the word goes to the buffer next cycle, the count resets, and the state stays SHIFT. This supports multi-word frames with no gap.
- cs_n rising in SHIFT:
  - count>0: frame_err pulses and the partial word is discarded.
  - count=0: no error.
  - In both cases, go to IDLE.
- A sample edge and cs_n rising in the same cycle: cs_n wins, and the edge is ignored.
- Latency: valid rises exactly 1 clk after the sample edge of the last bit is detected. This is p_sync_stages+2 clk after the external sck edge.
- Output buffer:
  - valid&&ready clears valid. data holds its value after being consumed.
  - Completion with valid=0: load data, valid=1.
  - Completion with valid=1 and ready=1 in the same cycle: load the new word, valid stays 1, no overrun.
  - Completion with valid=1 and ready=0: keep the old word, overrun pulses once.
- s_rst mid-frame: partial word lost, buffer cleared. Return to WAIT_IDLE, so a frame already in progress is never captured misaligned.

Decomposition:
- Package spi_pkg holds:
  - state typedef (WAIT_IDLE, IDLE, SHIFT)
  - mode constants SPI_MODE0..SPI_MODE3 as {cpol,cpha}
  - bit-count width function $clog2(p_data_width+1)
- Sub-module spi_edge_sync: parameterised synchronizer chain plus edge detector. Outputs sync level, rise pulse and fall pulse. Instantiated for sck; level-only for cs_n and mosi.

Test Plan:
1. Mode 0, sck=clk/8, ready=1, one frame with 8'h14 -> valid high for 1 cycle with data=8'h14, exactly p_sync_stages+2 clk after the 8th rising sck; no overrun or frame_err.
2. One cs_n frame carrying 8'h03 then 8'h57 back-to-back, ready=1 -> two valid pulses, data 8'h03 then 8'h57; busy high across the whole frame.
3. ready=0, words 8'h45 then 8'h12 -> data stays 8'h45 with valid held; overrun pulses once at the second completion. Then ready=1 -> one transfer of 8'h45, valid=0.
4. cs_n rises after 5 bits -> frame_err pulses once, no valid. Next frame 8'hA5 -> received correctly.
5. s_rst pulsed after 3 bits of a frame while cs_n stays low -> no valid for the rest of that frame. After cs_n rises, a new frame 8'h3C is received correctly.
6. Instance with p_cpol=1, p_cpha=1, frame 8'hC3 -> data=8'hC3 sampled on rising edges; word completion coincides with ready=1 while valid=1 -> no overrun.
